hier_icache_flush_sequencer: RTL and testbench

//  Sequences one cache-maintenance command (full flush or selective flush) across the shared L2 banks and private L1 caches.

---
 rtl/hier_icache_flush_sequencer.sv | 165 ++++++++++++++++
 tb/tb_hier_icache_flush_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hier_icache_flush_sequencer.sv
// Sequences one icache maintenance command: L2 banks first, then selected L1 cores, then a done pulse.
// Optional per-phase ack watchdog is built only when ICACHE_SEQ_TIMEOUT_EN is defined.
module hier_icache_flush_sequencer #(
  parameter int unsigned NB_CORES       = 9,
  parameter int unsigned NB_CACHE_BANKS = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_sel_i,
  input  logic [31:0]               cmd_addr_i,
  input  logic [NB_CORES-1:0]       cmd_core_mask_i,
  input  logic [NB_CACHE_BANKS-1:0] cmd_bank_mask_i,
  output logic [NB_CACHE_BANKS-1:0] L2_flush_req_o,
  output logic [NB_CACHE_BANKS-1:0] L2_sel_flush_req_o,
  input  logic [NB_CACHE_BANKS-1:0] L2_flush_ack_i,
  output logic [NB_CORES-1:0]       L1_flush_req_o,
  output logic [NB_CORES-1:0]       L1_sel_flush_req_o,
  input  logic [NB_CORES-1:0]       L1_flush_ack_i,
  output logic [31:0]               sel_flush_addr_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o
);

  typedef enum logic [1:0] {StIdle, StL2, StL1, StDone} state_e;

  state_e                    r_state;
  logic                      r_sel;
  logic [31:0]               r_addr;
  logic [NB_CORES-1:0]       r_core_mask;
  logic [NB_CACHE_BANKS-1:0] r_l2_full;
  logic [NB_CACHE_BANKS-1:0] r_l2_sel;
  logic [NB_CORES-1:0]       r_l1_full;
  logic [NB_CORES-1:0]       r_l1_sel;
  logic                      r_done;

  logic [NB_CACHE_BANKS-1:0] w_l2_left;
  logic [NB_CORES-1:0]       w_l1_left;

  // Pending bits are the request registers; an ack only clears a bit that is requested.
  assign w_l2_left = (r_l2_full | r_l2_sel) & ~L2_flush_ack_i;
  assign w_l1_left = (r_l1_full | r_l1_sel) & ~L1_flush_ack_i;

`ifdef ICACHE_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] r_cnt;
  logic            r_error;
  logic            w_expired;

  assign w_expired = (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
  assign error_o   = r_error;
`else
  // Watchdog not built; the parameter only matters for the timeout build.
  assign error_o = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_sel       <= 1'b0;
      r_addr      <= '0;
      r_core_mask <= '0;
      r_l2_full   <= '0;
      r_l2_sel    <= '0;
      r_l1_full   <= '0;
      r_l1_sel    <= '0;
      r_done      <= 1'b0;
`ifdef ICACHE_SEQ_TIMEOUT_EN
      r_cnt       <= '0;
      r_error     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef ICACHE_SEQ_TIMEOUT_EN
      r_cnt  <= r_cnt + CntW'(1);
`endif
      unique case (r_state)
        StIdle: begin
`ifdef ICACHE_SEQ_TIMEOUT_EN
          r_cnt <= '0;
`endif
          if (cmd_valid_i) begin
            r_sel       <= cmd_sel_i;
            r_addr      <= cmd_addr_i;
            r_core_mask <= cmd_core_mask_i;
`ifdef ICACHE_SEQ_TIMEOUT_EN
            r_error     <= 1'b0;
`endif
            if (|cmd_bank_mask_i) begin
              r_l2_full <= cmd_sel_i ? '0 : cmd_bank_mask_i;
              r_l2_sel  <= cmd_sel_i ? cmd_bank_mask_i : '0;
              r_state   <= StL2;
            end else if (|cmd_core_mask_i) begin
              r_l1_full <= cmd_sel_i ? '0 : cmd_core_mask_i;
              r_l1_sel  <= cmd_sel_i ? cmd_core_mask_i : '0;
              r_state   <= StL1;
            end else begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
        end
        StL2: begin
          r_l2_full <= r_l2_full & w_l2_left;
          r_l2_sel  <= r_l2_sel & w_l2_left;
          if (w_l2_left == '0) begin
`ifdef ICACHE_SEQ_TIMEOUT_EN
            r_cnt <= '0;
`endif
            if (|r_core_mask) begin
              r_l1_full <= r_sel ? '0 : r_core_mask;
              r_l1_sel  <= r_sel ? r_core_mask : '0;
              r_state   <= StL1;
            end else begin
              r_done  <= 1'b1;
              r_state <= StDone;
            end
          end
`ifdef ICACHE_SEQ_TIMEOUT_EN
          // A stuck bank abandons the whole command; L1 must not refill from unflushed L2.
          else if (w_expired) begin
            r_l2_full <= '0;
            r_l2_sel  <= '0;
            r_error   <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
`endif
        end
        StL1: begin
          r_l1_full <= r_l1_full & w_l1_left;
          r_l1_sel  <= r_l1_sel & w_l1_left;
          if (w_l1_left == '0) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end
`ifdef ICACHE_SEQ_TIMEOUT_EN
          else if (w_expired) begin
            r_l1_full <= '0;
            r_l1_sel  <= '0;
            r_error   <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
`endif
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o        = (r_state == StIdle);
  assign busy_o             = (r_state != StIdle);
  assign done_o             = r_done;
  assign sel_flush_addr_o   = r_addr;
  assign L2_flush_req_o     = r_l2_full;
  assign L2_sel_flush_req_o = r_l2_sel;
  assign L1_flush_req_o     = r_l1_full;
  assign L1_sel_flush_req_o = r_l1_sel;

endmodule

// File: tb/tb_hier_icache_flush_sequencer.sv
// Self-checking bench: set-based reference model per cycle, done_o scoreboard in a separate monitor.
// Timeout scenario is exercised only when ICACHE_SEQ_TIMEOUT_EN is defined.
module tb_hier_icache_flush_sequencer;
  localparam int unsigned NC = 9;
  localparam int unsigned NB = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          cmd_valid, cmd_sel, ready, busy, done, err;
  logic [31:0]   cmd_addr, sel_addr;
  logic [NC-1:0] cmd_cm, l1_freq, l1_sreq, l1_ack;
  logic [NB-1:0] cmd_bm, l2_freq, l2_sreq, l2_ack;

  always #5 clk = ~clk;

  hier_icache_flush_sequencer #(
    .NB_CORES      (NC),
    .NB_CACHE_BANKS(NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (ready),
    .cmd_sel_i         (cmd_sel),
    .cmd_addr_i        (cmd_addr),
    .cmd_core_mask_i   (cmd_cm),
    .cmd_bank_mask_i   (cmd_bm),
    .L2_flush_req_o    (l2_freq),
    .L2_sel_flush_req_o(l2_sreq),
    .L2_flush_ack_i    (l2_ack),
    .L1_flush_req_o    (l1_freq),
    .L1_sel_flush_req_o(l1_sreq),
    .L1_flush_ack_i    (l1_ack),
    .sel_flush_addr_o  (sel_addr),
    .busy_o            (busy),
    .done_o            (done),
    .error_o           (err)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: sets of targets still owed an ack, in flush order.
  bit            m_active;
  logic          m_sel;
  logic [31:0]   m_addr;
  logic [NB-1:0] m_l2;
  logic [NC-1:0] m_l1;
  bit            m_err;
  int            m_cnt;

  typedef struct {
    logic [31:0] addr;
    bit          err;
  } exp_t;
  exp_t sb_q[$];

  // Responder knobs
  int            d_l2[NB];
  int            d_l1[NC];
  int            age_l2[NB];
  int            age_l1[NC];
  bit            noise_en, junk_en, core5_poke;
  logic [NB-1:0] stuck_l2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NB-1:0] e_l2;
    logic [NC-1:0] e_l1;
    bit            e_done;
    e_l2   = m_active ? m_l2 : '0;
    e_l1   = (m_active && m_l2 == '0) ? m_l1 : '0;
    e_done = m_active && (m_l2 == '0) && (m_l1 == '0);
    chk("l2_flush_req", 32'(l2_freq), 32'(e_l2 & {NB{~m_sel}}));
    chk("l2_sel_req", 32'(l2_sreq), 32'(e_l2 & {NB{m_sel}}));
    chk("l1_flush_req", 32'(l1_freq), 32'(e_l1 & {NC{~m_sel}}));
    chk("l1_sel_req", 32'(l1_sreq), 32'(e_l1 & {NC{m_sel}}));
    chk("level_exclusive", 32'((|(l2_freq | l2_sreq)) && (|(l1_freq | l1_sreq))), 32'd0);
    chk("done", 32'(done), 32'(e_done));
    chk("ready", 32'(ready), 32'(!m_active));
    chk("busy", 32'(busy), 32'(m_active));
    chk("addr", sel_addr, m_addr);
    chk("error", 32'(err), 32'(m_err));
  endtask

  task automatic drive_acks();
    for (int i = 0; i < NB; i++) begin
      if (l2_freq[i] || l2_sreq[i]) begin
        l2_ack[i] = (age_l2[i] >= d_l2[i]) && !stuck_l2[i];
        age_l2[i]++;
      end else begin
        age_l2[i] = 0;
        l2_ack[i] = noise_en && ($urandom_range(3) == 0);
      end
    end
    for (int j = 0; j < NC; j++) begin
      if (l1_freq[j] || l1_sreq[j]) begin
        l1_ack[j] = (age_l1[j] >= d_l1[j]);
        age_l1[j]++;
      end else begin
        age_l1[j] = 0;
        l1_ack[j] = noise_en && ($urandom_range(3) == 0);
      end
    end
    if (core5_poke && (|(l2_freq | l2_sreq))) l1_ack[5] = 1'b1;
  endtask

  task automatic model_update(input bit issue, input logic sel, input logic [31:0] addr,
                              input logic [NB-1:0] bm, input logic [NC-1:0] cm);
    bit e_err;
    if (m_active) begin
      if (m_l2 != '0) begin
        m_l2 &= ~l2_ack;
        m_cnt++;
`ifdef ICACHE_SEQ_TIMEOUT_EN
        if (m_l2 != '0 && m_cnt == TO) begin
          m_l2  = '0;
          m_l1  = '0;
          m_err = 1'b1;
        end
`endif
        if (m_l2 == '0) m_cnt = 0;
      end else if (m_l1 != '0) begin
        m_l1 &= ~l1_ack;
        m_cnt++;
`ifdef ICACHE_SEQ_TIMEOUT_EN
        if (m_l1 != '0 && m_cnt == TO) begin
          m_l1  = '0;
          m_err = 1'b1;
        end
`endif
      end else begin
        m_active = 1'b0;
      end
    end else if (issue) begin
      m_active = 1'b1;
      m_sel    = sel;
      m_addr   = addr;
      m_l2     = bm;
      m_l1     = cm;
      m_err    = 1'b0;
      m_cnt    = 0;
      e_err    = 1'b0;
`ifdef ICACHE_SEQ_TIMEOUT_EN
      e_err = ((bm & stuck_l2) != '0);
`endif
      sb_q.push_back('{addr, e_err});
    end
  endtask

  task automatic step(input bit issue, input logic sel, input logic [31:0] addr,
                      input logic [NB-1:0] bm, input logic [NC-1:0] cm);
    check_outputs();
    drive_acks();
    if (issue) begin
      cmd_valid = 1'b1;
      cmd_sel   = sel;
      cmd_addr  = addr;
      cmd_bm    = bm;
      cmd_cm    = cm;
    end else if (junk_en && m_active && !(m_l2 == '0 && m_l1 == '0) &&
                 $urandom_range(2) == 0) begin
      // Command offered while busy must be ignored
      cmd_valid = 1'b1;
      cmd_sel   = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_bm    = NB'($urandom);
      cmd_cm    = NC'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    model_update(issue, sel, addr, bm, cm);
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 32'd0, '0, '0);
  endtask

  task automatic set_delays(input int l2d, input int l1d);
    for (int i = 0; i < NB; i++) d_l2[i] = (l2d < 0) ? int'($urandom_range(3)) : l2d;
    for (int j = 0; j < NC; j++) d_l1[j] = (l1d < 0) ? int'($urandom_range(3)) : l1d;
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    cmd_valid = 1'b0;
    l2_ack    = '0;
    l1_ack    = '0;
    #1;
    chk("rst_l2_req", 32'(l2_freq | l2_sreq), 32'd0);
    chk("rst_l1_req", 32'(l1_freq | l1_sreq), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    chk("rst_addr", sel_addr, 32'd0);
    m_active = 1'b0;
    m_sel    = 1'b0;
    m_addr   = '0;
    m_l2     = '0;
    m_l1     = '0;
    m_err    = 1'b0;
    m_cnt    = 0;
    sb_q.delete();
    for (int i = 0; i < NB; i++) age_l2[i] = 0;
    for (int j = 0; j < NC; j++) age_l1[j] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic run_cmd(input logic sel, input logic [31:0] addr,
                         input logic [NB-1:0] bm, input logic [NC-1:0] cm);
    int budget;
    step(1'b1, sel, addr, bm, cm);
    budget = 0;
    while (m_active && budget < 300) begin
      idle_step();
      budget++;
    end
    if (m_active) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_completion: still busy after %0d cycles, required done", budget);
      do_reset();
    end
  endtask

  // Scoreboard monitor: every done_o pulse must match the oldest outstanding command
  always @(negedge clk) begin
    exp_t e;
    if (rst_ni === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_unexpected: got done_o=1, required no completion pending");
      end else begin
        e = sb_q.pop_front();
        chk("sb_done_addr", sel_addr, e.addr);
        chk("sb_done_error", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_ni     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_sel    = 1'b0;
    cmd_addr   = '0;
    cmd_bm     = '0;
    cmd_cm     = '0;
    l2_ack     = '0;
    l1_ack     = '0;
    noise_en   = 1'b0;
    junk_en    = 1'b0;
    core5_poke = 1'b0;
    stuck_l2   = '0;
    set_delays(0, 0);
    @(negedge clk);
    do_reset();
    idle_step();

    // Full flush, every ack three cycles after its request
    set_delays(3, 3);
    run_cmd(1'b0, 32'hDEAD_BEEF, 4'hF, 9'h1FF);
    // Selective flush on one bank and two cores
    set_delays(1, 2);
    run_cmd(1'b1, 32'h1C00_8040, 4'b0100, 9'b0_0000_0011);
    // Nothing to flush
    run_cmd(1'b0, 32'h0000_1234, 4'h0, 9'h000);
    // Minimum latency path
    set_delays(0, 0);
    run_cmd(1'b1, 32'h0000_0040, 4'b0001, 9'h001);
    // Out-of-order bank acks (3,0,2,1) and a stray core 5 ack during the L2 phase
    d_l2[0] = 1; d_l2[1] = 3; d_l2[2] = 2; d_l2[3] = 0;
    for (int j = 0; j < NC; j++) d_l1[j] = 1;
    core5_poke = 1'b1;
    run_cmd(1'b0, 32'h0000_0100, 4'hF, 9'h023);
    core5_poke = 1'b0;

    // Reset in the middle of the L1 phase
    set_delays(0, 6);
    step(1'b1, 1'b0, 32'hCAFE_0000, 4'b0001, 9'h0F0);
    for (int k = 0; k < 3; k++) idle_step();
    chk("l1_pending_before_reset", 32'($countones(l1_freq)), 32'd4);
    do_reset();
    for (int k = 0; k < 4; k++) idle_step();

`ifdef ICACHE_SEQ_TIMEOUT_EN
    // Bank 3 never acks: watchdog fires, L1 phase skipped, error cleared by the next accept
    set_delays(1, 1);
    stuck_l2 = 4'b1000;
    run_cmd(1'b0, 32'h0000_0ABC, 4'b1001, 9'h003);
    stuck_l2 = '0;
    run_cmd(1'b1, 32'h0000_0DEF, 4'b0010, 9'h004);
`endif

    // Randomized traffic with stray/held acks and commands offered while busy
    noise_en = 1'b1;
    junk_en  = 1'b1;
    for (int n = 0; n < 60; n++) begin
      set_delays(-1, -1);
      run_cmd(1'($urandom), $urandom,
              ($urandom_range(3) == 0) ? '0 : NB'($urandom),
              ($urandom_range(3) == 0) ? '0 : NC'($urandom));
      if ($urandom_range(3) == 0) idle_step();
    end
    noise_en = 1'b0;
    junk_en  = 1'b0;
    idle_step();
    idle_step();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
